// File: rtl/sim_response_checker_pkg.sv
// Shared types and helpers for the response checker and its vector tables.
package sim_check_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_t;

    // Index width that never collapses to zero bits for tiny tables.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sim_response_checker_rom.sv
// DEPTH x WIDTH register table: synchronous write port, asynchronous read port.
// Used for expected values, masks, and as an upstream stimulus table.
module sim_vector_rom
    import sim_check_pkg::*;
#(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int              IDX_W   = clog2_min1(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [IDX_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RST_VAL;
            end
        end else if (wr_en_i && (int'(wr_addr_i) < DEPTH)) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/sim_response_checker.sv
// Walks a vector index, compares the DUT response against masked expected
// values with zero latency, and reports pass/fail, error count and first error.
module sim_response_checker
    import sim_check_pkg::*;
#(
    parameter int  WIDTH = 1,
    parameter int  DEPTH = 4,
    parameter int  CNT_W = 8,
    localparam int IDX_W = clog2_min1(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [IDX_W-1:0] load_addr,
    input  logic [WIDTH-1:0] load_data,
    input  logic [WIDTH-1:0] load_mask,
    input  logic             start,
    input  logic [WIDTH-1:0] dut_out,
    output logic [IDX_W-1:0] vec_idx,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [IDX_W-1:0] first_err_idx
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    chk_state_t       state_q, state_d;
    logic [IDX_W-1:0] vec_idx_q, vec_idx_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             first_err_valid_q, first_err_valid_d;
    logic [IDX_W-1:0] first_err_idx_q, first_err_idx_d;

    logic             wr_en;
    logic             start_run;
    logic             last_vec;
    logic             mismatch;
    logic [WIDTH-1:0] exp_rd;
    logic [WIDTH-1:0] mask_rd;

    assign wr_en     = load_en && (state_q == IDLE);
    assign start_run = start && ((state_q == IDLE) || (state_q == DONE));
    assign last_vec  = (vec_idx_q == LAST_IDX);
    // Combinational on this cycle's dut_out: the checker adds no latency.
    assign mismatch  = (state_q == RUN) && (|((dut_out ^ exp_rd) & mask_rd));

    sim_vector_rom #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL('0)) u_exp_rom (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en),
        .wr_addr_i (load_addr),
        .wr_data_i (load_data),
        .rd_addr_i (vec_idx_q),
        .rd_data_o (exp_rd)
    );

    // Masks reset to all-ones so an unloaded entry is fully compared.
    sim_vector_rom #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL('1)) u_mask_rom (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en),
        .wr_addr_i (load_addr),
        .wr_data_i (load_mask),
        .rd_addr_i (vec_idx_q),
        .rd_data_o (mask_rd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= IDLE;
            vec_idx_q         <= '0;
            err_count_q       <= '0;
            first_err_valid_q <= 1'b0;
            first_err_idx_q   <= '0;
        end else begin
            state_q           <= state_d;
            vec_idx_q         <= vec_idx_d;
            err_count_q       <= err_count_d;
            first_err_valid_q <= first_err_valid_d;
            first_err_idx_q   <= first_err_idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_run) state_d = RUN;
            RUN:     if (last_vec)  state_d = DONE;
            DONE:    if (start_run) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        vec_idx_d         = vec_idx_q;
        err_count_d       = err_count_q;
        first_err_valid_d = first_err_valid_q;
        first_err_idx_d   = first_err_idx_q;
        if (start_run) begin
            vec_idx_d         = '0;
            err_count_d       = '0;
            first_err_valid_d = 1'b0;
            first_err_idx_d   = '0;
        end else if (state_q == RUN) begin
            if (mismatch) begin
                if (err_count_q != CNT_MAX) err_count_d = err_count_q + 1'b1;
                if (!first_err_valid_q) begin
                    first_err_valid_d = 1'b1;
                    first_err_idx_d   = vec_idx_q;
                end
            end
            // The index parks on the last vector rather than wrapping.
            if (!last_vec) vec_idx_d = vec_idx_q + 1'b1;
        end
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
        pass = (state_q == DONE) && (err_count_q == '0);
    end

    assign vec_idx         = vec_idx_q;
    assign err_count       = err_count_q;
    assign first_err_valid = first_err_valid_q;
    assign first_err_idx   = first_err_idx_q;

endmodule
